scroll_sequencer: RTL and testbench
===================================

Name: scroll_sequencer

Overview:
- Game-flow sequencer directly upstream of the row renderer (erase/draw display controller).
- Owns tile-row contents, the vertical scroll offset and master_state; issues one startdraw/all_done render handshake per frame_tick.
- Generates new tile lanes with an LFSR, checks key hits against the bottom row, keeps score and declares a miss / game over.

Parameters:
- ROW_H, 40, pixel height of one row; offset wraps at this value (2..63).
- NUM_ROWS, 6, number of tile rows held; row 0 is top, row NUM_ROWS-1 is bottom.
- SPEED, 1, pixels the offset advances per frame (1..ROW_H-1).
- LFSR_SEED, 8'hA5, non-zero LFSR reset value.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous, active-low reset
- start  input  1  level; high = game running
- frame_tick  input  1  single-cycle frame pulse
- all_done  input  1  renderer finished frame (level)
- key  input  4  lane hit pulses, bit i = lane i+1, one cycle each, already edge-detected
- startdraw  output  1  render request to renderer
- offset  output  6  scroll offset, 0..ROW_H-1
- rows  output  3*NUM_ROWS  row i at [3i+2:3i]; 0 = empty, 1..4 = lane
- master_state  output  6  current state code
- score  output  8  hit count, saturating
- miss  output  1  one-cycle pulse on wrong key or missed tile
- game_over  output  1  high in GAME_OVER

Behaviour:
- Reset (async, resetn=0):
  - state IDLE, offset 0, rows all 0, score 0, LFSR LFSR_SEED, pending 0.
  - startdraw, miss and game_over all 0.
- All outputs are registered. master_state codes: IDLE=0, WAIT_TICK=1, DRAW=2, RELEASE=3, ADVANCE=4, GAME_OVER=5.
- IDLE: when start=1, clear rows, offset, score and pending, then go to WAIT_TICK. The LFSR is not reseeded.
- WAIT_TICK:
  - start=0 -> IDLE.
  - Otherwise frame_tick=1 -> DRAW.
  - frame_tick in any other state is ignored, not queued.
- DRAW: startdraw=1. all_done=1 -> RELEASE. start is ignored here so the renderer is never abandoned.
- RELEASE: startdraw=0. Wait for all_done=0, then go to ADVANCE.
- ADVANCE: single cycle, then WAIT_TICK or GAME_OVER.
  - Apply pending keys (below) to the pre-shift bottom row.
  - Compute s = offset + SPEED. If s < ROW_H, offset <= s.
  - Otherwise (wrap):
    - offset <= s - ROW_H.
    - Shift rows[i] <= rows[i-1] for i >= 1.
    - rows[0] <= {1'b0, lfsr[1:0]} + 1.
    - LFSR steps once (Fibonacci, taps 8,6,5,4; shift left, feedback into bit 0).
    - If the departing bottom row is still non-zero after key application: miss pulse, go to GAME_OVER.
- Key evaluation (one key vector k):
  - Ignored if k=0 or the bottom row is 0.
  - Hit when exactly one bit is set and index+1 equals the bottom row: bottom row <= 0, score+1 (holds at 255).
  - Otherwise (wrong lane or multiple bits): miss pulse only; no state change.
- Key timing:
  - In WAIT_TICK, key is evaluated in the same cycle; the result is visible next cycle.
  - In DRAW/RELEASE, key is ORed into a 4-bit pending register so rows stay stable during rendering.
  - In ADVANCE, k = pending | key. Pending clears after use.
  - Keys are ignored in IDLE and GAME_OVER.
- Hit and wrap in the same ADVANCE: the clear takes precedence, so the row departs empty and there is no miss.
- GAME_OVER: game_over=1, startdraw=0, rows and offset frozen. start=0 -> IDLE.
- Reset mid-DRAW: startdraw drops immediately. The renderer is reset from the same resetn.

Test Plan:
- Reset then start=1, 3 frame_ticks, each answered by all_done high 4 cycles then low -> master_state 0,1,2,3,4,1 sequence per tick; startdraw high only in DRAW; offset=3.
- Start and run 40 handshakes with SPEED=1 -> 40th ADVANCE has offset 39->0, rows[2:0] becomes (A5 LFSR bits[1:0])+1 = 2, other rows shifted.
- Preload bottom row=3, key=4'b0100 in WAIT_TICK -> bottom row 0, score 1, no miss. Then key=4'b0001 with bottom row 2 -> miss pulse, score unchanged.
- Bottom row=1, no key, offset reaches wrap -> miss pulse and GAME_OVER (master_state 5, game_over=1). start=0 -> IDLE; start=1 -> score 0, rows 0.
- key=4'b0001 pulsed during DRAW with bottom row 1 and the wrap on the following ADVANCE -> rows unchanged through DRAW/RELEASE; at ADVANCE score+1, no miss, no GAME_OVER.
- frame_tick during DRAW ignored; start=0 during DRAW -> handshake completes, ADVANCE runs, WAIT_TICK then IDLE; assert resetn=0 mid-DRAW -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/scroll_sequencer.sv
// Game-flow sequencer ahead of the row renderer: owns tile rows, scroll offset
// and score, and issues one startdraw/all_done render handshake per frame_tick.
module scroll_sequencer #(
   parameter int unsigned ROW_H     = 40,
   parameter int unsigned NUM_ROWS  = 6,
   parameter int unsigned SPEED     = 1,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic                  frame_tick,
   input  logic                  all_done,
   input  logic [3:0]            key,
   output logic                  startdraw,
   output logic [5:0]            offset,
   output logic [3*NUM_ROWS-1:0] rows,
   output logic [5:0]            master_state,
   output logic [7:0]            score,
   output logic                  miss,
   output logic                  game_over
);

   typedef enum logic [5:0] {
      S_IDLE      = 6'd0,
      S_WAIT_TICK = 6'd1,
      S_DRAW      = 6'd2,
      S_RELEASE   = 6'd3,
      S_ADVANCE   = 6'd4,
      S_GAME_OVER = 6'd5
   } state_t;

   localparam logic [6:0] SPEED_W = 7'(SPEED);
   localparam logic [6:0] ROW_H_W = 7'(ROW_H);

   state_t                     r_state;
   logic [5:0]                 r_offset;
   logic [NUM_ROWS-1:0][2:0]   r_rows;
   logic [7:0]                 r_score;
   logic [7:0]                 r_lfsr;
   logic [3:0]                 r_pending;
   logic                       r_startdraw;
   logic                       r_miss;
   logic                       r_game_over;

   logic [3:0] w_key;
   logic [2:0] w_bottom;
   logic [2:0] w_lane;
   logic       w_onehot;
   logic       w_hit;
   logic       w_wrong;
   logic [6:0] w_sum;
   logic       w_wrap;
   logic [2:0] w_depart;
   logic       w_lfsr_fb;
   logic [7:0] w_score_inc;

   // Render handshake: startdraw is held high from entry into DRAW until the
   // cycle all_done is seen high; the frame only advances once all_done has
   // been seen low again, so a level-held all_done never spans two frames.
   always_comb begin
      w_key    = (r_state == S_ADVANCE) ? (r_pending | key) : key;
      w_bottom = r_rows[NUM_ROWS-1];
      w_lane   = 3'd0;
      w_onehot = 1'b0;
      case (w_key)
         4'b0001: begin w_lane = 3'd1; w_onehot = 1'b1; end
         4'b0010: begin w_lane = 3'd2; w_onehot = 1'b1; end
         4'b0100: begin w_lane = 3'd3; w_onehot = 1'b1; end
         4'b1000: begin w_lane = 3'd4; w_onehot = 1'b1; end
         default: ;
      endcase
      w_hit       = w_onehot && (w_bottom != 3'd0) && (w_lane == w_bottom);
      w_wrong     = (w_key != 4'd0) && (w_bottom != 3'd0) && !w_hit;
      w_sum       = {1'b0, r_offset} + SPEED_W;
      w_wrap      = (w_sum >= ROW_H_W);
      // A hit on the same ADVANCE as the wrap lets the row leave empty.
      w_depart    = w_hit ? 3'd0 : w_bottom;
      w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
      w_score_inc = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_offset    <= 6'd0;
         r_rows      <= '0;
         r_score     <= 8'd0;
         r_lfsr      <= LFSR_SEED;
         r_pending   <= 4'd0;
         r_startdraw <= 1'b0;
         r_miss      <= 1'b0;
         r_game_over <= 1'b0;
      end else begin
         r_miss <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_rows    <= '0;
                  r_offset  <= 6'd0;
                  r_score   <= 8'd0;
                  r_pending <= 4'd0;
                  r_state   <= S_WAIT_TICK;
               end
            end
            S_WAIT_TICK: begin
               if (w_hit) begin
                  r_rows[NUM_ROWS-1] <= 3'd0;
                  r_score            <= w_score_inc;
               end
               if (w_wrong) r_miss <= 1'b1;
               if (!start) begin
                  r_state <= S_IDLE;
               end else if (frame_tick) begin
                  r_state     <= S_DRAW;
                  r_startdraw <= 1'b1;
               end
            end
            S_DRAW: begin
               r_pending <= r_pending | key;
               if (all_done) begin
                  r_state     <= S_RELEASE;
                  r_startdraw <= 1'b0;
               end
            end
            S_RELEASE: begin
               r_pending <= r_pending | key;
               if (!all_done) r_state <= S_ADVANCE;
            end
            S_ADVANCE: begin
               r_pending <= 4'd0;
               r_state   <= S_WAIT_TICK;
               if (w_hit) r_score <= w_score_inc;
               if (w_wrong) r_miss <= 1'b1;
               if (!w_wrap) begin
                  r_offset <= w_sum[5:0];
                  if (w_hit) r_rows[NUM_ROWS-1] <= 3'd0;
               end else begin
                  r_offset <= 6'(w_sum - ROW_H_W);
                  for (int i = 1; i < NUM_ROWS; i++) r_rows[i] <= r_rows[i-1];
                  r_rows[0] <= {1'b0, r_lfsr[1:0]} + 3'd1;
                  r_lfsr    <= {r_lfsr[6:0], w_lfsr_fb};
                  if (w_depart != 3'd0) begin
                     r_miss      <= 1'b1;
                     r_state     <= S_GAME_OVER;
                     r_game_over <= 1'b1;
                  end
               end
            end
            S_GAME_OVER: begin
               if (!start) begin
                  r_state     <= S_IDLE;
                  r_game_over <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign startdraw    = r_startdraw;
   assign offset       = r_offset;
   assign rows         = r_rows;
   assign master_state = r_state;
   assign score        = r_score;
   assign miss         = r_miss;
   assign game_over    = r_game_over;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Bench for scroll_sequencer: a behavioural game model feeds an expected-snapshot
// queue that is compared against the DUT at each observable step.
module tb_scroll_sequencer;
   localparam int NUM_ROWS = 6;
   localparam int ROW_H    = 40;
   localparam int SPEED    = 1;
   localparam int W        = 41;

   logic                  clk = 1'b0;
   logic                  resetn = 1'b0;
   logic                  start = 1'b0;
   logic                  frame_tick = 1'b0;
   logic                  all_done = 1'b0;
   logic [3:0]            key = 4'd0;
   logic                  startdraw;
   logic [5:0]            offset;
   logic [3*NUM_ROWS-1:0] rows;
   logic [5:0]            master_state;
   logic [7:0]            score;
   logic                  miss;
   logic                  game_over;

   scroll_sequencer #(
      .ROW_H(ROW_H), .NUM_ROWS(NUM_ROWS), .SPEED(SPEED), .LFSR_SEED(8'hA5)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start), .frame_tick(frame_tick),
      .all_done(all_done), .key(key), .startdraw(startdraw), .offset(offset),
      .rows(rows), .master_state(master_state), .score(score), .miss(miss),
      .game_over(game_over)
   );

   always #5 clk = ~clk;

   int           n_vec = 0;
   int           n_err = 0;
   logic [W-1:0] exp_q[$];

   int         m_rows[NUM_ROWS];
   int         m_offset;
   int         m_score;
   logic [7:0] m_lfsr;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] dut_snap();
      return {master_state, offset, rows, score, miss, game_over, startdraw};
   endfunction

   function automatic logic [W-1:0] model_snap(input int st, input bit m);
      logic [3*NUM_ROWS-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_ROWS; i++) r[3*i +: 3] = m_rows[i][2:0];
      return {6'(st), 6'(m_offset), r, 8'(m_score), m, (st == 5), (st == 2)};
   endfunction

   task automatic pop_cmp(input string tag);
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         chk(tag, dut_snap(), exp_q.pop_front());
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NUM_ROWS; i++) m_rows[i] = 0;
      m_offset = 0;
      m_score  = 0;
   endtask

   // Returns 1 when the key vector counts as a miss.
   function automatic bit model_key(input logic [3:0] k);
      int b;
      int lane;
      b = m_rows[NUM_ROWS-1];
      if (k == 4'd0 || b == 0) return 1'b0;
      case (k)
         4'b0001: lane = 1;
         4'b0010: lane = 2;
         4'b0100: lane = 3;
         4'b1000: lane = 4;
         default: lane = 0;
      endcase
      if (lane == b) begin
         m_rows[NUM_ROWS-1] = 0;
         if (m_score < 255) m_score++;
         return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_advance(input logic [3:0] k, output int st, output bit m);
      int s;
      int dep;
      m  = model_key(k);
      st = 1;
      s  = m_offset + SPEED;
      if (s < ROW_H) begin
         m_offset = s;
      end else begin
         m_offset = s - ROW_H;
         dep = m_rows[NUM_ROWS-1];
         for (int i = NUM_ROWS - 1; i > 0; i--) m_rows[i] = m_rows[i-1];
         m_rows[0] = int'(m_lfsr[1:0]) + 1;
         m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
         if (dep != 0) begin
            m  = 1'b1;
            st = 5;
         end
      end
   endtask

   // Key pulse in WAIT_TICK; effect visible on the next sample.
   task automatic press_key(input logic [3:0] k, input string tag);
      bit m;
      m = model_key(k);
      exp_q.push_back(model_snap(1, m));
      key = k;
      @(negedge clk);
      key = 4'd0;
      pop_cmp(tag);
   endtask

   // One full frame from WAIT_TICK: tick, DRAW, RELEASE, ADVANCE, result.
   task automatic do_frame(input logic [3:0] draw_key, input int done_cycles,
                           input bit tick_in_draw, input bit drop_start);
      int st;
      bit m;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      exp_q.push_back(model_snap(2, 1'b0));
      pop_cmp("draw");
      all_done   = 1'b1;
      key        = draw_key;
      frame_tick = tick_in_draw;
      if (drop_start) start = 1'b0;
      @(negedge clk);
      key        = 4'd0;
      frame_tick = 1'b0;
      exp_q.push_back(model_snap(3, 1'b0));
      pop_cmp("release");
      repeat (done_cycles - 1) @(negedge clk);
      all_done = 1'b0;
      @(negedge clk);
      exp_q.push_back(model_snap(4, 1'b0));
      pop_cmp("advance");
      model_advance(draw_key, st, m);
      exp_q.push_back(model_snap(st, m));
      @(negedge clk);
      pop_cmp("post_advance");
   endtask

   initial begin
      int b;
      for (int i = 0; i < NUM_ROWS; i++) m_rows[i] = 0;
      m_offset = 0;
      m_score  = 0;
      m_lfsr   = 8'hA5;

      repeat (3) @(negedge clk);
      chk("reset_snap", dut_snap(), '0);
      resetn = 1'b1;
      @(negedge clk);
      chk("idle_hold", master_state, 6'd0);

      start = 1'b1;
      model_clear();
      exp_q.push_back(model_snap(1, 1'b0));
      @(negedge clk);
      pop_cmp("start_to_wait");

      for (int f = 0; f < 3; f++) do_frame(4'd0, 4, 1'b0, 1'b0);
      chk("offset_after_3", offset, 6'd3);

      for (int f = 3; f < 40; f++) do_frame(4'd0, $urandom_range(1, 4), 1'b0, 1'b0);
      chk("wrap40_offset", offset, 6'd0);
      chk("wrap40_row0", rows[2:0], 3'd2);
      chk("wrap40_rest", rows[3*NUM_ROWS-1:3], '0);

      // Keys against an empty bottom row must do nothing.
      while (m_rows[NUM_ROWS-1] == 0) begin
         if ($urandom_range(0, 7) == 0) press_key(4'($urandom_range(1, 15)), "key_ignored");
         do_frame(4'd0, $urandom_range(1, 4), 1'b0, 1'b0);
      end

      b = m_rows[NUM_ROWS-1];
      press_key(4'(1 << (b % 4)), "wrong_lane");
      press_key(4'b0011, "multi_key");
      press_key(4'(1 << (b - 1)), "hit_wait_tick");
      chk("score_after_hit", score, 8'd1);

      while (m_offset + SPEED < ROW_H) do_frame(4'd0, $urandom_range(1, 4), 1'b0, 1'b0);
      do_frame(4'd0, 2, 1'b0, 1'b0);
      chk("empty_departure", master_state, 6'd1);

      b = m_rows[NUM_ROWS-1];
      while (m_offset + SPEED < ROW_H) do_frame(4'd0, $urandom_range(1, 4), 1'b0, 1'b0);
      do_frame(4'(1 << (b - 1)), 3, 1'b0, 1'b0);
      chk("pending_hit_score", score, 8'd2);
      chk("pending_hit_no_over", game_over, 1'b0);

      while (m_offset + SPEED < ROW_H) do_frame(4'd0, $urandom_range(1, 4), 1'b0, 1'b0);
      do_frame(4'd0, 2, 1'b0, 1'b0);
      chk("game_over_state", master_state, 6'd5);
      chk("game_over_flag", game_over, 1'b1);

      exp_q.push_back(model_snap(5, 1'b0));
      frame_tick = 1'b1;
      key        = 4'b1111;
      @(negedge clk);
      frame_tick = 1'b0;
      key        = 4'd0;
      pop_cmp("game_over_frozen");

      start = 1'b0;
      exp_q.push_back(model_snap(0, 1'b0));
      @(negedge clk);
      pop_cmp("over_to_idle");
      start = 1'b1;
      model_clear();
      exp_q.push_back(model_snap(1, 1'b0));
      @(negedge clk);
      pop_cmp("restart_clear");

      do_frame(4'd0, 2, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      chk("tick_in_draw_ignored", master_state, 6'd1);

      do_frame(4'd0, 2, 1'b0, 1'b1);
      @(negedge clk);
      chk("stop_after_frame", master_state, 6'd0);

      start = 1'b1;
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      chk("draw_before_reset", startdraw, 1'b1);
      #2 resetn = 1'b0;
      #1 chk("async_reset_mid_draw", dut_snap(), '0);
      @(negedge clk);
      resetn = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
